// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream arbitration blocks.
package stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width that stays legal (>= 1 bit) even for a single-entry space.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_burst_arbiter_if.sv
// Bundle of per-source request streams and the shared downstream stream.
interface stream_burst_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int DW      = 32,
    parameter int IDW     = 1
);
    logic [NUM_SRC*DW-1:0] s_data_i;
    logic [NUM_SRC-1:0]    s_valid_i;
    logic [NUM_SRC-1:0]    s_last_i;
    logic [NUM_SRC-1:0]    s_ready_o;
    logic [DW-1:0]         m_data_o;
    logic                  m_valid_o;
    logic                  m_last_o;
    logic [IDW-1:0]        m_id_o;
    logic                  m_ready_i;
    logic                  busy_o;

    // Arbiter side.
    modport slave (
        input  s_data_i, s_valid_i, s_last_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o, m_last_o, m_id_o, busy_o
    );

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output s_data_i, s_valid_i, s_last_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o, m_last_o, m_id_o, busy_o
    );
endinterface

// File: rtl/stream_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module stream_rr_pick
    import stream_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDW     = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     win_o,
    output logic               any_o
);

    int idx;

    // Scan from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        idx   = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (req_i[idx]) win_o = idx[IDW-1:0];
        end
    end

endmodule

// File: rtl/stream_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one stream path among NUM_SRC sources.
module stream_burst_arbiter
    import stream_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int DW        = 32,
    parameter int BURST_LEN = 4,
    parameter int IDW       = idx_w(NUM_SRC)
) (
    input logic                  clk,
    input logic                  rst,
    stream_burst_arbiter_if.slave bus
);

    localparam int             CW      = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BURST_LEN - 1);
    localparam logic [IDW-1:0] SEL_MAX = IDW'(NUM_SRC - 1);

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     sel_q, sel_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     pick_win;
    logic               pick_any;
    logic [NUM_SRC-1:0] s_ready;
    logic [DW-1:0]      m_data;
    logic               m_valid;
    logic               m_last;

    stream_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_pick (
        .req_i (bus.s_valid_i),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        s_ready = '0;
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_win;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                m_valid        = bus.s_valid_i[sel_q];
                m_data         = bus.s_data_i[sel_q*DW +: DW];
                s_ready[sel_q] = bus.m_ready_i;
                m_last         = m_valid & (bus.s_last_i[sel_q] | (cnt_q == CNT_MAX));
                if (m_valid && bus.m_ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    // Served source drops to lowest priority for the next arbitration.
                    if (m_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        ptr_d   = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = m_data;
    assign bus.m_valid_o = m_valid;
    assign bus.m_last_o  = m_last;
    assign bus.m_id_o    = sel_q;
    assign bus.busy_o    = (state_q == GRANT);

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Self-checking bench for stream_burst_arbiter (NUM_SRC=2, BURST_LEN=4) and stream_rr_pick.
module tb_stream_burst_arbiter;
    import stream_pkg::*;

    localparam int NS = 2;
    localparam int DW = 32;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_burst_arbiter_if #(.NUM_SRC(NS), .DW(DW), .IDW(1)) bus ();

    stream_burst_arbiter #(
        .NUM_SRC   (NS),
        .DW        (DW),
        .BURST_LEN (BL),
        .IDW       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] preq;
    logic [1:0] pptr;
    logic [1:0] pwin;
    logic       pany;

    stream_rr_pick #(.NUM_SRC(3), .IDW(2)) u_pick3 (
        .req_i (preq),
        .ptr_i (pptr),
        .win_o (pwin),
        .any_o (pany)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] src_data [NS][64];
    logic          src_last [NS][64];
    int            src_pos  [NS];
    logic          src_en   [NS];

    logic          obs_busy, obs_valid, obs_last, obs_xfer;
    logic [0:0]    obs_id;
    logic [NS-1:0] obs_ready;
    logic [DW-1:0] obs_data;

    typedef struct {
        logic [0:0]    id;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            bus.s_valid_i[i]          = src_en[i];
            bus.s_data_i[i*DW +: DW]  = src_data[i][src_pos[i]];
            bus.s_last_i[i]           = src_last[i][src_pos[i]];
        end
    endtask

    // Sample outputs at the falling edge, then advance sources that handshook.
    task automatic step();
        logic hs [NS];
        @(negedge clk);
        obs_busy  = bus.busy_o;
        obs_valid = bus.m_valid_o;
        obs_last  = bus.m_last_o;
        obs_id    = bus.m_id_o;
        obs_ready = bus.s_ready_o;
        obs_data  = bus.m_data_o;
        obs_xfer  = bus.m_valid_o & bus.m_ready_i;
        for (int i = 0; i < NS; i++) hs[i] = bus.s_ready_o[i] & bus.s_valid_i[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (hs[i] && src_pos[i] < 63) src_pos[i]++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_en[i]  = 1'b0;
            src_pos[i] = 0;
            for (int k = 0; k < 64; k++) begin
                src_data[i][k] = DW'(i * 100 + k + 1);
                src_last[i][k] = 1'b0;
            end
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        n_tests++;
        if ({obs_busy, obs_valid, obs_last, obs_id, obs_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b required 00000", {obs_busy, obs_valid, obs_last, obs_id, obs_ready});
        end
        rst = 1'b1;
        src_en[0] = 1'b1;
        drive();
        step();
        step();
        n_tests++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_holds_idle got busy=%b valid=%b required 0 0", obs_busy, obs_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        int beat = 0;
        logic expv;
        do_reset();
        src_en[0] = 1'b1;
        bus.m_ready_i = 1'b1;
        drive();
        for (int c = 0; c < 10; c++) begin
            step();
            expv = !(c == 0 || c == 5);
            n_tests++;
            if (obs_valid !== expv || obs_busy !== expv) begin
                n_fail++;
                $display("FAIL single_valid c=%0d got v=%b busy=%b required %b", c, obs_valid, obs_busy, expv);
            end
            if (expv) begin
                beat++;
                n_tests++;
                if (obs_data !== DW'(beat) || obs_last !== (beat % 4 == 0) || obs_id !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_beat c=%0d got d=%0d l=%b id=%0d required d=%0d l=%b id=0",
                             c, obs_data, obs_last, obs_id, beat, (beat % 4 == 0));
                end
            end
        end
    endtask

    task automatic test_contention();
        int g, b, s;
        do_reset();
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        bus.m_ready_i = 1'b1;
        drive();
        for (int c = 0; c <= 20; c++) begin
            step();
            n_tests++;
            if (c % 5 == 0) begin
                if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_ready !== 2'b00) begin
                    n_fail++;
                    $display("FAIL contention_bubble c=%0d got busy=%b v=%b rdy=%b required 0 0 00",
                             c, obs_busy, obs_valid, obs_ready);
                end
            end else begin
                g = (c - 1) / 5;
                b = (c - 1) % 5;
                s = g % 2;
                if (obs_valid !== 1'b1 || obs_id !== s[0] || obs_data !== DW'(s * 100 + (g / 2) * 4 + b + 1)
                    || obs_last !== (b == 3) || obs_ready !== NS'(1 << s)) begin
                    n_fail++;
                    $display("FAIL contention_beat c=%0d got v=%b id=%0d d=%0d l=%b rdy=%b required 1 %0d %0d %b %b",
                             c, obs_valid, obs_id, obs_data, obs_last, obs_ready,
                             s, s * 100 + (g / 2) * 4 + b + 1, (b == 3), NS'(1 << s));
                end
            end
        end
    endtask

    task automatic test_early_last();
        do_reset();
        src_last[1][1] = 1'b1;
        src_en[1] = 1'b1;
        bus.m_ready_i = 1'b1;
        drive();
        step();
        step();
        n_tests++;
        if (obs_valid !== 1'b1 || obs_id !== 1'b1 || obs_data !== DW'(101) || obs_last !== 1'b0) begin
            n_fail++;
            $display("FAIL early_beat1 got v=%b id=%0d d=%0d l=%b required 1 1 101 0", obs_valid, obs_id, obs_data, obs_last);
        end
        step();
        n_tests++;
        if (obs_valid !== 1'b1 || obs_id !== 1'b1 || obs_data !== DW'(102) || obs_last !== 1'b1) begin
            n_fail++;
            $display("FAIL early_beat2 got v=%b id=%0d d=%0d l=%b required 1 1 102 1", obs_valid, obs_id, obs_data, obs_last);
        end
        src_en[0] = 1'b1;
        drive();
        step();
        n_tests++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_bubble got busy=%b v=%b required 0 0", obs_busy, obs_valid);
        end
        step();
        n_tests++;
        if (obs_valid !== 1'b1 || obs_id !== 1'b0 || obs_data !== DW'(1)) begin
            n_fail++;
            $display("FAIL early_next_grant got v=%b id=%0d d=%0d required 1 0 1", obs_valid, obs_id, obs_data);
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        do_reset();
        src_en[0] = 1'b1;
        bus.m_ready_i = 1'b0;
        drive();
        for (int c = 0; c < 60 && got < 8; c++) begin
            step();
            if (obs_busy) begin
                n_tests++;
                if (obs_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_valid_held c=%0d got %b required 1", c, obs_valid);
                end
            end
            if (obs_xfer) begin
                got++;
                n_tests++;
                if (obs_data !== DW'(got) || obs_last !== (got % 4 == 0) || obs_id !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_beat n=%0d got d=%0d l=%b id=%0d required d=%0d l=%b id=0",
                             got, obs_data, obs_last, obs_id, got, (got % 4 == 0));
                end
            end
            bus.m_ready_i = ~bus.m_ready_i;
        end
        n_tests++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL bp_count got %0d beats required 8", got);
        end
    endtask

    task automatic test_valid_gap();
        do_reset();
        src_en[0] = 1'b1;
        bus.m_ready_i = 1'b1;
        drive();
        repeat (3) step();
        src_en[0] = 1'b0;
        src_en[1] = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (obs_busy !== 1'b1 || obs_valid !== 1'b0 || obs_id !== 1'b0 || obs_ready !== 2'b01) begin
                n_fail++;
                $display("FAIL gap_hold c=%0d got busy=%b v=%b id=%0d rdy=%b required 1 0 0 01",
                         c, obs_busy, obs_valid, obs_id, obs_ready);
            end
        end
        src_en[0] = 1'b1;
        drive();
        for (int b = 3; b <= 4; b++) begin
            step();
            n_tests++;
            if (obs_valid !== 1'b1 || obs_id !== 1'b0 || obs_data !== DW'(b) || obs_last !== (b == 4)) begin
                n_fail++;
                $display("FAIL gap_resume b=%0d got v=%b id=%0d d=%0d l=%b required 1 0 %0d %b",
                         b, obs_valid, obs_id, obs_data, obs_last, b, (b == 4));
            end
        end
        step();
        step();
        n_tests++;
        if (obs_valid !== 1'b1 || obs_id !== 1'b1 || obs_data !== DW'(101)) begin
            n_fail++;
            $display("FAIL gap_next_grant got v=%b id=%0d d=%0d required 1 1 101", obs_valid, obs_id, obs_data);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        bus.m_ready_i = 1'b1;
        drive();
        repeat (7) step();
        step();
        n_tests++;
        if (obs_valid !== 1'b1 || obs_id !== 1'b1 || obs_data !== DW'(102)) begin
            n_fail++;
            $display("FAIL rstmid_pre got v=%b id=%0d d=%0d required 1 1 102", obs_valid, obs_id, obs_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if (obs_busy !== 1'b0 || obs_ready !== 2'b00 || obs_id !== 1'b0 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle got busy=%b rdy=%b id=%0d v=%b required 0 00 0 0",
                     obs_busy, obs_ready, obs_id, obs_valid);
        end
        step();
        n_tests++;
        if (obs_valid !== 1'b1 || obs_id !== 1'b0 || obs_data !== DW'(5)) begin
            n_fail++;
            $display("FAIL rstmid_next got v=%b id=%0d d=%0d required 1 0 5", obs_valid, obs_id, obs_data);
        end
    endtask

    task automatic test_rr_pick();
        logic       exp_any;
        logic [1:0] exp_win;
        logic       found;
        int         idx;
        for (int t = 0; t < 40; t++) begin
            preq = 3'($urandom_range(0, 7));
            pptr = 2'($urandom_range(0, 2));
            #1;
            exp_any = 1'b0;
            exp_win = 2'd0;
            found   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                idx = (int'(pptr) + k) % 3;
                if (!found && preq[idx]) begin
                    found   = 1'b1;
                    exp_any = 1'b1;
                    exp_win = 2'(idx);
                end
            end
            n_tests++;
            if (pany !== exp_any || (exp_any && pwin !== exp_win)) begin
                n_fail++;
                $display("FAIL rr_pick req=%b ptr=%0d got any=%b win=%0d required any=%b win=%0d",
                         preq, pptr, pany, pwin, exp_any, exp_win);
            end
        end
    endtask

    // Both sources always requesting: grants must alternate, each a burst cut by last or length.
    task automatic test_random();
        beat_t expq[$];
        beat_t e;
        int    p [NS];
        int    s;
        logic  l;
        logic  prev_end = 1'b0;
        do_reset();
        for (int i = 0; i < NS; i++) begin
            p[i] = 0;
            for (int k = 0; k < 64; k++) begin
                src_data[i][k] = {8'(i), 24'($urandom)};
                src_last[i][k] = ($urandom_range(0, 3) == 0);
            end
        end
        for (int g = 0; g < 20; g++) begin
            s = g % 2;
            for (int n = 0; n < BL; n++) begin
                l = src_last[s][p[s]] || (n == BL - 1);
                e.id = s[0];
                e.d  = src_data[s][p[s]];
                e.l  = l;
                expq.push_back(e);
                p[s]++;
                if (l) break;
            end
        end
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        bus.m_ready_i = 1'($urandom_range(0, 1));
        drive();
        for (int c = 0; c < 2000 && expq.size() > 0; c++) begin
            step();
            if (prev_end) begin
                n_tests++;
                if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_bubble c=%0d got busy=%b v=%b required 0 0", c, obs_busy, obs_valid);
                end
            end
            if (obs_xfer) begin
                e = expq.pop_front();
                n_tests++;
                if (obs_id !== e.id || obs_data !== e.d || obs_last !== e.l) begin
                    n_fail++;
                    $display("FAIL rand_beat c=%0d got id=%0d d=%h l=%b required id=%0d d=%h l=%b",
                             c, obs_id, obs_data, obs_last, e.id, e.d, e.l);
                end
            end
            prev_end = obs_xfer & obs_last;
            bus.m_ready_i = 1'($urandom_range(0, 1));
        end
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain got %0d beats left required 0", expq.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        preq = '0;
        pptr = '0;
        test_reset();
        test_single_burst();
        test_contention();
        test_early_last();
        test_backpressure();
        test_valid_gap();
        test_reset_mid_burst();
        test_rr_pick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_burst_arbiter.md
# stream_burst_arbiter

Round-robin scheduler that shares one downstream stream path (typically a `stream_upsizer` feeding the SD/DMA write path) between `NUM_SRC` requesting streams. It grants one source at a time for a whole burst of `BURST_LEN` beats, or fewer if the source ends its packet early. This keeps a downstream upsizer word from mixing data from different sources. It tags each output beat with the index of the source that produced it.

## Interface
- `NUM_SRC`, default 2: number of requesters, at least 2.
- `DW`, default 32: data width per beat.
- `BURST_LEN`, default 4: maximum beats per grant, at least 1. Set it to a multiple of the downstream upsizer `SCALE`.
- `IDW`, default `$clog2(NUM_SRC)`: width of the source index.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `s_data_i` in `NUM_SRC*DW`: source data; source i occupies bits `[i*DW +: DW]`.
- `s_valid_i` in `NUM_SRC`: per-source valid.
- `s_last_i` in `NUM_SRC`: per-source end of packet.
- `s_ready_o` out `NUM_SRC`: per-source ready.
- `m_data_o` out `DW`: data from the granted source.
- `m_valid_o` out 1: output valid.
- `m_last_o` out 1: final beat of the current grant.
- `m_id_o` out `IDW`: index of the granted source.
- `m_ready_i` in 1: downstream ready.
- `busy_o` out 1: a grant is active.

## Operation
- **States:**
  - `IDLE`: no grant.
  - `GRANT`: one source owns the output.
- **IDLE:**
  - If any `s_valid_i` bit is set, pick the winner round-robin. The search starts at `ptr`, wraps modulo `NUM_SRC`, and takes the first set bit.
  - Register the winner in `sel`, clear `cnt`, and go to `GRANT`.
  - With no requests, stay in `IDLE`.
- **GRANT, datapath (combinational pass-through, no registering):**
  - `m_valid_o = s_valid_i[sel]`
  - `m_data_o = s_data_i[sel]`
  - `s_ready_o[sel] = m_ready_i`
  - `s_ready_o` for every other source is 0.
- **Beat transfer:** a beat transfers when `m_valid_o & m_ready_i`. Each transfer increments `cnt`. `cnt` is `$clog2(BURST_LEN+1)` bits wide and never exceeds `BURST_LEN-1` while in `GRANT`.
- **`m_last_o`:** equals `m_valid_o & (s_last_i[sel] | cnt == BURST_LEN-1)`.
- **End of grant:**
  - On a transfer with `m_last_o` set, go to `IDLE`.
  - Set `ptr` to `sel+1`, wrapping to 0 when `sel == NUM_SRC-1`. The source just served gets the lowest priority next time.
- **No pre-emption:** if the granted source drops `s_valid_i` mid-burst, the grant holds and the output stalls. No timeout.
- **Idle outputs:** in `IDLE`, `m_valid_o`, `m_last_o` and all `s_ready_o` bits are 0. `m_id_o` holds the last `sel`.
- **`busy_o`:** equals `state == GRANT`.

## Timing
- **Reset values:**
  - Registers: `state = IDLE`, `sel = 0`, `ptr = 0`, `cnt = 0`.
  - Outputs: `m_valid_o`, `m_last_o`, `busy_o` and `s_ready_o` are 0; `m_id_o` is 0.
  - After reset, source 0 has top priority.
- **Arbitration latency:**
  - A request seen in `IDLE` in cycle N gives `m_valid_o` in cycle N+1.
  - There is exactly one bubble cycle in `IDLE` between consecutive grants, even when requests are continuous.
- **Data latency:** zero cycles within a grant (combinational valid/ready/data).
- **Simultaneous last and count:** `s_last_i` and `cnt == BURST_LEN-1` on the same beat end the grant once. The counter does not carry over.
- **`BURST_LEN == 1`:** every transfer ends the grant.
- **Reset mid-burst:** return to `IDLE` on the next edge and drop the in-flight grant. The downstream upsizer must share `rst`, so no partial word survives.
- **Handshake rule:** `m_valid_o` never depends on `m_ready_i`.

## Structure
- **Shared package `stream_pkg`:**
  - State enum `arb_state_t` (`IDLE`, `GRANT`).
  - Function `idx_w(n)`, which returns `n > 1 ? $clog2(n) : 1`.
- **Sub-module `stream_rr_pick`:** combinational. Inputs: request vector and `ptr`. Outputs: winner index and `any`. It is instanced once and tested standalone.
- **Remainder:** the FSM, counter and muxes live in `stream_burst_arbiter`.

## Test plan
- **Single source burst:** reset, hold `s_valid_i=2'b01` with data 1..8, `m_ready_i=1`, `BURST_LEN=4`.
  - `m_id_o=0`; beats 1–4 with `m_last_o` on beat 4.
  - One idle cycle, then beats 5–8.
- **Contention:** `s_valid_i=2'b11` continuous.
  - Grants alternate 0,1,0,1, each of 4 beats, with one bubble between grants.
  - The source that is not granted sees `s_ready_o=0` throughout.
- **Early last:** source 1 asserts `s_last_i` on its 2nd beat.
  - Grant ends after 2 beats with `m_last_o=1`; `ptr=0`.
- **Backpressure:** toggle `m_ready_i` every cycle.
  - No beat is lost or duplicated; `cnt` advances only on transfer; order is preserved.
- **Valid gap:** the granted source drops valid for 3 cycles mid-burst.
  - `busy_o` stays 1, `m_valid_o=0`; the grant resumes and completes with no other source served.
- **Reset mid-burst:** assert `rst` after 2 beats.
  - Next cycle: `busy_o=0`, all `s_ready_o=0`, `m_id_o=0`; the next grant goes to source 0.
